// File: rtl/alg_pkg.sv
// ---------------------------------------------------------------------------
// alg_pkg
// Shared definitions for the calculator ALU slice: the opcode encoding,
// operand/result widths and the code driven out on a divide by zero.
// No ports (package).
// ---------------------------------------------------------------------------
package alg_pkg;

  localparam int ALG_W     = 4;
  localparam int ALG_RES_W = 8;

  // Result driven when a division by zero is requested.
  localparam logic [ALG_RES_W-1:0] DIV0_RESULT = 8'hFF;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_SHL = 3'b111
  } op_e;

endpackage

// File: rtl/alg_divider.sv
// ---------------------------------------------------------------------------
// alg_divider
// Combinational unsigned restoring divider.
// Ports:
//   dividend    in  W  numerator
//   divisor     in  W  denominator
//   quotient    out W  dividend / divisor
//   remainder   out W  dividend % divisor
//   div_by_zero out 1  divisor is zero (quotient/remainder are then don't-care)
// ---------------------------------------------------------------------------
module alg_divider
  import alg_pkg::*;
#(
  parameter int W = ALG_W
) (
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  logic [W-1:0] partial;
  logic [W:0]   trial;

  // Long division, one dividend bit per step from the MSB down. The running
  // partial remainder is always below the divisor, so it fits in W bits;
  // only the shifted trial value needs the extra bit.
  always_comb begin
    partial  = '0;
    trial    = '0;
    quotient = '0;
    for (int i = W - 1; i >= 0; i--) begin
      trial = {partial, dividend[i]};
      if (trial >= {1'b0, divisor}) begin
        partial     = W'(trial - {1'b0, divisor});
        quotient[i] = 1'b1;
      end else begin
        partial = trial[W-1:0];
      end
    end
    remainder = partial;
  end

  assign div_by_zero = (divisor == '0);

endmodule

// File: rtl/alg_core.sv
// ---------------------------------------------------------------------------
// alg_core
// Eight-function 4-bit ALU for the calculator datapath. Operands are sampled
// when in_valid is high and the result is registered on the same edge, so
// out/err/out_valid are available one cycle after issue.
// Ports:
//   clk       in  1    system clock, rising edge
//   rst_n     in  1    asynchronous active-low reset
//   in_valid  in  1    a, b and op are sampled this cycle
//   a, b      in  W    unsigned operands
//   op        in  3    opcode (see alg_pkg::op_e)
//   out       out 2W   registered result
//   out_valid out 1    out/err carry a new result this cycle
//   err       out 1    result invalid (division by zero)
// Optional (macro ALG_STATUS_EN):
//   zero      out 1    registered out == 0
//   carry     out 1    ADD carry out of bit W-1, SUB borrow; 0 otherwise
// ---------------------------------------------------------------------------
module alg_core
  import alg_pkg::*;
#(
  parameter int W = ALG_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2:0]     op,
  output logic [2*W-1:0] out,
  output logic           out_valid,
  output logic           err
`ifdef ALG_STATUS_EN
  ,
  output logic           zero,
  output logic           carry
`endif
);

  localparam int RES_W = 2 * W;

  op_e              opCode;
  logic [RES_W-1:0] aExt;
  logic [RES_W-1:0] bExt;
  logic [RES_W-1:0] resNext;
  logic             errNext;
  logic [W-1:0]     divQuot;
  logic [W-1:0]     divRem;
  logic             divZero;

  assign opCode = op_e'(op);
  assign aExt   = RES_W'(a);
  assign bExt   = RES_W'(b);

  alg_divider #(.W(W)) u_divider (
    .dividend   (a),
    .divisor    (b),
    .quotient   (divQuot),
    .remainder  (divRem),
    .div_by_zero(divZero)
  );

  // Result selection. Everything is done at the full result width so that
  // SUB wraps to two's complement and MUL keeps its whole product.
  always_comb begin
    resNext = '0;
    errNext = 1'b0;
    case (opCode)
      OP_ADD: resNext = aExt + bExt;
      OP_SUB: resNext = aExt - bExt;
      OP_MUL: resNext = aExt * bExt;
      OP_DIV: begin
        if (divZero) begin
          resNext = RES_W'(DIV0_RESULT);
          errNext = 1'b1;
        end else begin
          resNext = {divRem, divQuot};
        end
      end
      OP_AND: resNext = RES_W'(a & b);
      OP_OR:  resNext = RES_W'(a | b);
      OP_XOR: resNext = RES_W'(a ^ b);
      // Only the low two bits of b form the shift amount.
      OP_SHL: resNext = aExt << b[1:0];
      default: begin
        resNext = '0;
        errNext = 1'b0;
      end
    endcase
  end

  // Output register. out_valid simply follows in_valid; out and err only
  // load on a valid issue so they hold through idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= resNext;
        err <= errNext;
      end
    end
  end

`ifdef ALG_STATUS_EN
  logic [W:0] addWide;
  logic       zeroNext;
  logic       carryNext;

  assign addWide = {1'b0, a} + {1'b0, b};

  // Status flags are derived from the same operation that loads out.
  always_comb begin
    zeroNext  = (resNext == '0);
    carryNext = 1'b0;
    case (opCode)
      OP_ADD:  carryNext = addWide[W];
      OP_SUB:  carryNext = (a < b);
      default: carryNext = 1'b0;
    endcase
  end

  // Flags register alongside out so they always describe the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero  <= 1'b0;
      carry <= 1'b0;
    end else if (in_valid) begin
      zero  <= zeroNext;
      carry <= carryNext;
    end
  end
`endif

endmodule

// File: tb/tb_alg_core.sv
// ---------------------------------------------------------------------------
// tb_alg_core
// Self-checking bench for alg_core: directed sequences plus a randomized run
// checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alg_core;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] op;
  logic [7:0] out;
  logic       out_valid;
  logic       err;
`ifdef ALG_STATUS_EN
  logic       zero;
  logic       carry;
`endif

  int compared;
  int mismatched;

  alg_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .op       (op),
    .out      (out),
    .out_valid(out_valid),
    .err      (err)
`ifdef ALG_STATUS_EN
    ,
    .zero     (zero),
    .carry    (carry)
`endif
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model computed straight from the opcode definitions using
  // integer arithmetic; the low byte of a negative int is its 8-bit
  // two's complement.
  function automatic void refModel(input int ra, input int rb, input int rop,
                                   output logic [7:0] res, output logic rerr,
                                   output logic rzero, output logic rcarry);
    int r;
    rerr   = 1'b0;
    rcarry = 1'b0;
    case (rop)
      0: begin r = ra + rb; rcarry = (ra + rb) > 15; end
      1: begin r = ra - rb; rcarry = ra < rb; end
      2: r = ra * rb;
      3: begin
        if (rb == 0) begin
          r    = 255;
          rerr = 1'b1;
        end else begin
          r = (ra % rb) * 16 + (ra / rb);
        end
      end
      4: r = ra & rb;
      5: r = ra | rb;
      6: r = ra ^ rb;
      default: r = ra * (1 << (rb % 4));
    endcase
    res   = r[7:0];
    rzero = (res == 8'h00);
  endfunction

  // Drive one set of inputs half a cycle ahead of the sampling edge.
  task automatic applyStimulus(input logic v, input logic [3:0] ta,
                               input logic [3:0] tb, input logic [2:0] to);
    @(negedge clk);
    in_valid = v;
    a        = ta;
    b        = tb;
    op       = to;
  endtask

  // Move to just after the next rising edge, where outputs are stable.
  task automatic waitSample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'($urandom), 4'($urandom), 3'($urandom));
      waitSample();
      compared++;
      if (out !== 8'h00 || out_valid !== 1'b0 || err !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_hold[%0d]: got out=%h valid=%b err=%b, expected out=00 valid=0 err=0",
                 i, out, out_valid, err);
      end
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // First valid input after reset is a normal result.
    applyStimulus(1'b1, 4'd5, 4'd6, 3'd0);
    waitSample();
    compared++;
    if (out !== 8'h0B || out_valid !== 1'b1 || err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL first_after_reset: got out=%h valid=%b err=%b, expected out=0b valid=1 err=0",
               out, out_valid, err);
    end

    // Asynchronous assertion between edges clears outputs at once.
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (out !== 8'h00 || out_valid !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got out=%h valid=%b err=%b, expected out=00 valid=0 err=0",
               out, out_valid, err);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    logic [2:0] tOp[5]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [3:0] tA[5]   = '{4'd0, 4'd1, 4'd12, 4'd7, 4'd14};
    logic [3:0] tB[5]   = '{4'd0, 4'd2, 4'd11, 4'd1, 4'd1};
    logic [7:0] tExp[5] = '{8'h00, 8'hFF, 8'h84, 8'h07, 8'h0F};
    $display("[TB] test_arith");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, tA[i], tB[i], tOp[i]);
      waitSample();
      compared++;
      if (out !== tExp[i] || out_valid !== 1'b1 || err !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL arith[%0d]: got out=%h valid=%b err=%b, expected out=%h valid=1 err=0",
                 i, out, out_valid, err, tExp[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [2:0] tOp[5]  = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
    logic [3:0] tA[5]   = '{4'h8, 4'hF, 4'hA, 4'hC, 4'hF};
    logic [3:0] tB[5]   = '{4'h2, 4'hF, 4'h5, 4'h3, 4'hB};
    logic [7:0] tExp[5] = '{8'h00, 8'h0F, 8'h0F, 8'h60, 8'h78};
    $display("[TB] test_logic");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, tA[i], tB[i], tOp[i]);
      waitSample();
      compared++;
      if (out !== tExp[i] || out_valid !== 1'b1 || err !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL logic[%0d]: got out=%h valid=%b err=%b, expected out=%h valid=1 err=0",
                 i, out, out_valid, err, tExp[i]);
      end
    end
  endtask

  task automatic test_divide();
    logic [2:0] tOp[3]  = '{3'd3, 3'd3, 3'd0};
    logic [3:0] tA[3]   = '{4'd15, 4'd9, 4'd1};
    logic [3:0] tB[3]   = '{4'd4, 4'd0, 4'd1};
    logic [7:0] tExp[3] = '{8'h33, 8'hFF, 8'h02};
    logic       tErr[3] = '{1'b0, 1'b1, 1'b0};
    $display("[TB] test_divide");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, tA[i], tB[i], tOp[i]);
      waitSample();
      compared++;
      if (out !== tExp[i] || out_valid !== 1'b1 || err !== tErr[i]) begin
        mismatched++;
        $display("[TB] FAIL divide[%0d]: got out=%h valid=%b err=%b, expected out=%h valid=1 err=%b",
                 i, out, out_valid, err, tExp[i], tErr[i]);
      end
    end
  endtask

  task automatic test_valid();
    $display("[TB] test_valid");
    applyStimulus(1'b1, 4'd3, 4'd4, 3'd0);
    waitSample();
    compared++;
    if (out !== 8'h07 || out_valid !== 1'b1 || err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL valid_issue: got out=%h valid=%b err=%b, expected out=07 valid=1 err=0",
               out, out_valid, err);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'($urandom), 4'($urandom), 3'($urandom));
      waitSample();
      compared++;
      if (out !== 8'h07 || out_valid !== 1'b0 || err !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL valid_hold[%0d]: got out=%h valid=%b err=%b, expected out=07 valid=0 err=0",
                 i, out, out_valid, err);
      end
    end
  endtask

`ifdef ALG_STATUS_EN
  task automatic test_status();
    logic [2:0] tOp[3]    = '{3'd0, 3'd1, 3'd1};
    logic [3:0] tA[3]     = '{4'd15, 4'd3, 4'd2};
    logic [3:0] tB[3]     = '{4'd1, 4'd3, 4'd5};
    logic [7:0] tExp[3]   = '{8'h10, 8'h00, 8'hFD};
    logic       tZero[3]  = '{1'b0, 1'b1, 1'b0};
    logic       tCarry[3] = '{1'b1, 1'b0, 1'b1};
    $display("[TB] test_status");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, tA[i], tB[i], tOp[i]);
      waitSample();
      compared++;
      if (out !== tExp[i] || zero !== tZero[i] || carry !== tCarry[i]) begin
        mismatched++;
        $display("[TB] FAIL status[%0d]: got out=%h zero=%b carry=%b, expected out=%h zero=%b carry=%b",
                 i, out, zero, carry, tExp[i], tZero[i], tCarry[i]);
      end
    end
  endtask
`endif

  // Random mix of valid and idle cycles; the model tracks the held values.
  task automatic test_random();
    logic [7:0] expOut;
    logic       expErr;
    logic       expZero;
    logic       expCarry;
    logic [7:0] mOut;
    logic       mErr;
    logic       mZero;
    logic       mCarry;
    logic       v;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] ro;
    $display("[TB] test_random");
    expOut   = 8'h00;
    expErr   = 1'b0;
    expZero  = 1'b0;
    expCarry = 1'b0;
    for (int i = 0; i < 300; i++) begin
      v  = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      ra = 4'($urandom);
      rb = 4'($urandom);
      ro = 3'($urandom);
      if (v) begin
        refModel(int'(ra), int'(rb), int'(ro), mOut, mErr, mZero, mCarry);
        expOut   = mOut;
        expErr   = mErr;
        expZero  = mZero;
        expCarry = mCarry;
      end
      applyStimulus(v, ra, rb, ro);
      waitSample();
      compared++;
      if (out !== expOut || out_valid !== v || err !== expErr) begin
        mismatched++;
        $display("[TB] FAIL random[%0d] op=%0d a=%0d b=%0d: got out=%h valid=%b err=%b, expected out=%h valid=%b err=%b",
                 i, ro, ra, rb, out, out_valid, err, expOut, v, expErr);
      end
`ifdef ALG_STATUS_EN
      compared++;
      if (zero !== expZero || carry !== expCarry) begin
        mismatched++;
        $display("[TB] FAIL random_status[%0d]: got zero=%b carry=%b, expected zero=%b carry=%b",
                 i, zero, carry, expZero, expCarry);
      end
`endif
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    a          = 4'h0;
    b          = 4'h0;
    op         = 3'h0;

    test_reset();
    test_arith();
    test_logic();
    test_divide();
    test_valid();
`ifdef ALG_STATUS_EN
    test_status();
`endif
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alg_core.md
Name: alg_core

Overview:
- 4-bit, eight-function arithmetic/logic unit for the calculator datapath.
- Takes two unsigned 4-bit operands and a 3-bit opcode, and returns an 8-bit registered result.
- Sits between the keypad/operand registers and the display formatter.
- Has one-cycle latency, a valid qualifier on input and output, and an error flag for division by zero.

Parameters:
- W, 4, operand width; the result width is 2*W; only W=4 needs to be verified.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a, b and op are sampled on this cycle.
- a  in  4  operand A, unsigned.
- b  in  4  operand B, unsigned.
- op  in  3  opcode.
- out  out  8  result, registered.
- out_valid  out  1  out and err hold a new result this cycle.
- err  out  1  the current result is invalid (division by zero).

Behaviour:
- Reset: asserting rst_n low asynchronously clears out=8'h00, out_valid=0 and err=0. Release is synchronous to clk.
- Latency: when in_valid=1 at rising edge N, out and err are updated at that edge, and out_valid=1 for exactly that cycle.
- When in_valid=0: out_valid drops to 0 at the next edge, and out and err hold their previous values.
- There is no backpressure; a new operation may be issued every cycle.
- Opcodes. Operands are zero-extended to 8 bits; results are truncated to 8 bits.
  - 000 ADD: a+b, range 0..30.
  - 001 SUB: a-b, 8-bit two's complement (1-2 = 8'hFF).
  - 010 MUL: a*b, range 0..225, never overflows.
  - 011 DIV: out = {remainder[3:0], quotient[3:0]}.
  - 100 AND: {4'h0, a&b}.
  - 101 OR: {4'h0, a|b}.
  - 110 XOR: {4'h0, a^b}.
  - 111 SHL: {4'h0, a} << b[1:0]; b[3:2] is ignored; maximum result is 8'h78.
- Division by zero (op=011, b=0): out=8'hFF, err=1.
- err=0 for every other operation, including SUB underflow.
- Purely combinational compute feeds a single output register; there is no FSM.
- Reset asserted mid-stream discards any in-flight result; the first valid input after reset produces a normal result.

Optional Feature:
- Macro ALG_STATUS_EN.
- When defined, two extra registered outputs are added, both updated with out:
  - zero (1): out == 0.
  - carry (1): for ADD, the carry out of bit 3; for SUB, a borrow (a<b); 0 for all other ops.
  - Both reset to 0.
- When not defined, these ports are absent and behaviour is otherwise identical.

Decomposition:
- Package alg_pkg holds:
  - the opcode enum: OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_SHL.
  - the constants ALG_W=4 and ALG_RES_W=8.
  - the divide-by-zero code DIV0_RESULT=8'hFF.
- Sub-module alg_divider: a combinational 4-bit unsigned restoring divider.
  - Inputs: dividend and divisor.
  - Outputs: quotient, remainder and div_by_zero.
  - Instantiated once inside alg_core.

Test Plan:
- Reset: hold rst_n=0 across several clk edges with random inputs -> out=00, out_valid=0, err=0. Assert rst_n asynchronously between edges -> outputs clear immediately.
- Arithmetic sequence, in_valid=1 each cycle:
  - ADD 0+0 -> 00.
  - SUB 1-2 -> FF, err=0.
  - MUL 12*11 -> 84.
  - DIV 7/1 -> 07.
  - ADD 14+1 -> 0F.
  - Each result appears one cycle after issue, with out_valid=1.
- Logic sequence:
  - AND 8&2 -> 00.
  - OR F|F -> 0F.
  - XOR A^5 -> 0F.
  - SHL 12<<3 -> 60.
  - SHL a=15, b=4'hB -> 78.
- Division edge cases:
  - 15/4 -> 33 (remainder 3, quotient 3).
  - 9/0 -> FF with err=1.
  - The next op (ADD 1+1) -> 02 with err=0.
- Valid handling: issue ADD 3+4 then deassert in_valid for 3 cycles while changing a, b and op -> out stays 07, out_valid=1 for one cycle only.
- With ALG_STATUS_EN:
  - ADD 15+1 -> out=10, carry=1.
  - SUB 3-3 -> out=00, zero=1, carry=0.
  - SUB 2-5 -> out=FD, carry=1.
